// File: rtl/dds_i2c_scheduler.sv
// dds_i2c_scheduler: round-robin arbiter feeding NUM_CH DDS sample slots into one byte-level I2C write engine
//
// Ports:
//   clk, reset               single clock, synchronous active-high reset
//   sample_valid/_data/_ready per-channel one-entry holding slot (data of channel i at [8i+7:8i])
//   ch_addr                  7-bit slave address per channel, sampled at grant
//   byte_req/_start/_stop/_data  byte command to the I2C engine, held until byte_done
//   byte_done, byte_nack     engine completion pulse and ACK status
//   busy                     scheduler not idle
//   tx_done, err_valid, evt_ch   per-sample completion / drop report and its channel
//   drop_cnt                 saturating drop counter, present only with DDS_SCHED_STATS_EN defined
module dds_i2c_scheduler #(
    parameter int NUM_CH    = 2,
    parameter int MAX_RETRY = 3,
    parameter int RETRY_GAP = 16,
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_CH-1:0]     sample_valid,
    input  logic [8*NUM_CH-1:0]   sample_data,
    output logic [NUM_CH-1:0]     sample_ready,
    input  logic [7*NUM_CH-1:0]   ch_addr,
    output logic                  byte_req,
    output logic                  byte_start,
    output logic                  byte_stop,
    output logic [7:0]            byte_data,
    input  logic                  byte_done,
    input  logic                  byte_nack,
    output logic                  busy,
    output logic                  tx_done,
    output logic                  err_valid,
`ifdef DDS_SCHED_STATS_EN
    output logic [15:0]           drop_cnt,
`endif
    output logic [CH_W-1:0]       evt_ch
);
    localparam int GW = $clog2(RETRY_GAP + 1);

    typedef enum logic [2:0] {IDLE, ARB, ADDR, DATA, RETRY} state_t;

    state_t            state, state_nx;
    logic [NUM_CH-1:0] pending;
    logic [7:0]        slot [NUM_CH];
    logic [CH_W-1:0]   last, grant, arb_sel, idx;
    logic [6:0]        addr_q, addr_sel;
    logic [7:0]        data_q;
    logic [3:0]        retry_cnt;
    logic [GW-1:0]     gap_cnt;
    logic              ack_done, nack_done, drop, clear, last_try;
    logic              req_d, start_d, stop_d, tx_d, err_d;
    logic [7:0]        data_d;

    assign ack_done     = byte_done & ~byte_nack;
    assign nack_done    = byte_done & byte_nack;
    assign last_try     = retry_cnt == 4'(MAX_RETRY);
    assign drop         = (state == RETRY) && last_try;
    assign clear        = ((state == DATA) && ack_done) || drop;
    assign sample_ready = ~pending;
    assign addr_sel     = ch_addr[7*int'(arb_sel) +: 7];

    // Scan downwards so the nearest pending index after 'last' is written last and wins.
    always_comb begin
        arb_sel = last;
        idx     = last;
        for (int k = NUM_CH; k >= 1; k--) begin
            idx = CH_W'((int'(last) + k) % NUM_CH);
            if (pending[idx]) arb_sel = idx;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = |pending ? ARB : IDLE;
            ARB:     state_nx = ADDR;
            ADDR:    state_nx = byte_done ? (byte_nack ? RETRY : DATA) : ADDR;
            DATA:    state_nx = byte_done ? (byte_nack ? RETRY : IDLE) : DATA;
            RETRY:   state_nx = drop ? IDLE : (gap_cnt == GW'(RETRY_GAP - 1)) ? ADDR : RETRY;
            default: state_nx = IDLE;
        endcase
    end

    // Outputs are registered from the next state so the byte command is valid on the same edge the FSM enters ADDR/DATA.
    always_comb begin
        req_d   = (state_nx == ADDR) || (state_nx == DATA);
        start_d = state_nx == ADDR;
        stop_d  = state_nx == DATA;
        data_d  = (state_nx == ADDR) ? {(state == ARB) ? addr_sel : addr_q, 1'b0} :
                  (state_nx == DATA) ? data_q : byte_data;
        tx_d    = (state == DATA) && ack_done;
        err_d   = ((state == ADDR) || (state == DATA)) && nack_done && last_try;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending   <= '0;
            last      <= CH_W'(NUM_CH - 1);
            grant     <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            retry_cnt <= '0;
            gap_cnt   <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++)
                if (sample_valid[i] && !pending[i]) begin
                    pending[i] <= 1'b1;
                    slot[i]    <= sample_data[8*i +: 8];
                end
            if (clear) begin
                pending[grant] <= 1'b0;
                last           <= grant;
            end
            if (state == ARB) begin
                grant     <= arb_sel;
                addr_q    <= addr_sel;
                data_q    <= slot[arb_sel];
                retry_cnt <= '0;
            end
            if (((state == ADDR) || (state == DATA)) && nack_done) gap_cnt <= '0;
            if (state == RETRY) gap_cnt <= gap_cnt + 1'b1;
            if ((state == RETRY) && (state_nx == ADDR)) retry_cnt <= retry_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            byte_req   <= 1'b0;
            byte_start <= 1'b0;
            byte_stop  <= 1'b0;
            byte_data  <= '0;
            busy       <= 1'b0;
            tx_done    <= 1'b0;
            err_valid  <= 1'b0;
            evt_ch     <= '0;
        end else begin
            byte_req   <= req_d;
            byte_start <= start_d;
            byte_stop  <= stop_d;
            byte_data  <= data_d;
            busy       <= state_nx != IDLE;
            tx_done    <= tx_d;
            err_valid  <= err_d;
            if (tx_d || err_d) evt_ch <= grant;
        end
    end

`ifdef DDS_SCHED_STATS_EN
    always_ff @(posedge clk) begin
        if (reset)                         drop_cnt <= '0;
        else if (err_d && ~&drop_cnt)      drop_cnt <= drop_cnt + 16'd1;
    end
`endif

endmodule

// File: doc/dds_i2c_scheduler.md
# dds_i2c_scheduler

Round-robin scheduler that shares one byte-level I2C write engine between NUM_CH DDS sample producers. Each channel deposits an 8-bit sample into a one-entry holding slot. The scheduler picks the next pending channel and issues a two-byte write: the address byte with START, then the data byte with STOP. On NACK it retries up to MAX_RETRY times, then drops the sample and reports an error. It sits between the DDS sine generators and the shared I2C bit engine that drives scl/sda.

## Interface
- NUM_CH, 2: number of producer channels, 1..8; CH_W = (NUM_CH>1) ? $clog2(NUM_CH) : 1
- MAX_RETRY, 3: retries after the first NACKed attempt, 0..15
- RETRY_GAP, 16: idle cycles between a NACK and the re-attempt, ≥1
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- sample_valid  in  NUM_CH  per-channel sample offered
- sample_data  in  8*NUM_CH  channel i at [8i+7:8i]
- sample_ready  out  NUM_CH  per-channel slot free; sample_ready[i] = ~pending[i]
- ch_addr  in  7*NUM_CH  7-bit slave address of channel i; sampled when the channel is granted
- byte_req  out  1  byte command valid; level, held until byte_done
- byte_start  out  1  engine emits START before this byte
- byte_stop  out  1  engine emits STOP after this byte
- byte_data  out  8  byte to shift, MSB first
- byte_done  in  1  1-cycle pulse, byte plus ACK slot finished
- byte_nack  in  1  valid only with byte_done; 1 = slave NACKed, and the engine has already issued STOP
- busy  out  1  state ≠ IDLE
- tx_done  out  1  1-cycle pulse, sample acknowledged
- err_valid  out  1  1-cycle pulse, sample dropped after retries exhausted
- evt_ch  out  CH_W  channel for tx_done/err_valid; holds its last value otherwise

## Operation
- Slots: pending[i] is set on sample_valid[i] & sample_ready[i], and the slot data is captured on the same edge. Because ready is registered-low while pending, a capture and a clear of the same slot never occur in one cycle.
- The slot is cleared on the cycle the FSM leaves DATA through success, or leaves RETRY through drop.
- States:
  - IDLE: if any pending -> ARB.
  - ARB: grant the first pending index scanning last+1, last+2, … wrapping modulo NUM_CH. Latch grant, address and data. Set retry_cnt=0. -> ADDR.
  - ADDR: byte_req=1, byte_start=1, byte_stop=0, byte_data={addr,1'b0}. On done: ACK -> DATA; NACK -> RETRY.
  - DATA: byte_req=1, byte_start=0, byte_stop=1, byte_data=sample. On done: ACK -> IDLE, pulse tx_done, last=grant; NACK -> RETRY.
  - RETRY: if retry_cnt==MAX_RETRY, clear the slot, pulse err_valid, set last=grant, -> IDLE. Otherwise wait RETRY_GAP cycles, increment retry_cnt, -> ADDR, reusing the latched addr/data.
- A retry always restarts from the address byte.
- byte_done outside ADDR/DATA is ignored.
- Reset value of last = NUM_CH-1, so channel 0 wins the first arbitration.
- byte_data/start/stop are stable for the whole time byte_req is high.

## Timing
- All outputs are registered.
- Reset values: sample_ready=all 1s, byte_req=0, byte_start=0, byte_stop=0, byte_data=0, busy=0, tx_done=0, err_valid=0, evt_ch=0. Internally, pending=0 and state=IDLE.
- A sample captured at edge N reaches ARB at N+1 and ADDR at N+2, so byte_req rises at N+2 when the FSM was idle.
- byte_req falls on the edge after byte_done. For an ACKed address, DATA re-asserts byte_req on that same edge, leaving no gap cycle.
- tx_done/err_valid/evt_ch update on the edge after the deciding byte_done.
- sample_ready[i] returns high one edge after the slot clears.
- Reset mid-transaction abandons the transfer at the next edge: byte_req drops and the slots clear. The I2C engine shares this reset.
- Worst-case occupancy per sample: (MAX_RETRY+1) attempts plus MAX_RETRY*RETRY_GAP cycles.

## Configuration
- DDS_SCHED_STATS_EN defined: adds the output drop_cnt[15:0], a saturating count of err_valid pulses across all channels. It resets to 0 and holds at 16'hFFFF.
- Not defined: no port, no counter logic.
- All other behaviour is identical in both builds.

## Test plan
- Single write: NUM_CH=2; ch0 valid, data 8'hA5, ch_addr0=7'h4D, model always ACKs. Expected bytes are 8'h9A with start=1, then 8'hA5 with stop=1; tx_done pulse with evt_ch=0; sample_ready[0] returns to 1.
- Fairness: both channels are continuously valid. Grants alternate 0,1,0,1 over 8 transactions; neither channel is served twice in a row.
- Address NACK then ACK: the first ADDR is NACKed. Exactly RETRY_GAP=16 cycles with byte_req=0, then 8'h9A again; the transfer completes with one tx_done and no err_valid.
- Exhausted retries: every byte is NACKed with MAX_RETRY=3. Exactly 4 address attempts, then an err_valid pulse with evt_ch=grant and the slot freed. With DDS_SCHED_STATS_EN, drop_cnt goes 0->1.
- Data NACK: the address is ACKed and the data is NACKed once. The retry restarts at the address byte (start=1); no tx_done until the data byte is ACKed.
- Reset during DATA: assert reset for 1 cycle while byte_req=1. On the next edge byte_req=0, busy=0, sample_ready=all 1s, and no tx_done/err_valid is emitted.
